// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, times multi-cycle EX ops and
// issues a one-cycle flush with redirect PC. Optional counters: PIPE_STALL_CNT_EN.
module pipe_ctrl #(
    parameter int MULTI_CYCLES = 32,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_mem,
    input  logic        ex_multi_start,
    input  logic        excp_valid,
    input  logic [31:0] excp_target,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        multi_busy,
    output logic        multi_done,
    output logic [1:0]  state_dbg
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    // Handshake: none; every input is a level request sampled on each rising clk edge.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MULTI = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      flush_pc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            flush_pc <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            flush_pc <= flush_pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        flush_pc_nxt = flush_pc;
        multi_busy   = 1'b0;
        multi_done   = 1'b0;
        flush        = 1'b0;
        case (state)
            S_IDLE: begin
                // An exception in the same cycle as a start drops the start.
                if (excp_valid) begin
                    state_nxt    = S_FLUSH;
                    flush_pc_nxt = excp_target;
                end else if (ex_multi_start) begin
                    state_nxt = S_MULTI;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            S_MULTI: begin
                multi_busy = 1'b1;
                if (excp_valid) begin
                    state_nxt    = S_FLUSH;
                    cnt_nxt      = '0;
                    flush_pc_nxt = excp_target;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (!stallreq_mem) begin
                    // Result is only handed over once MEM can accept it.
                    multi_done = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            S_FLUSH: begin
                flush     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stall vector is a prefix mask; the boundary between stalled and running
    // stages is where the consuming register inserts a bubble.
    always_comb begin
        stall = 6'b000000;
        if (state == S_FLUSH)                       stall = 6'b000000;
        else if (stallreq_mem)                      stall = 6'b011111;
        else if (state == S_MULTI && !multi_done)   stall = 6'b001111;
        else if (stallreq_id)                       stall = 6'b000111;
        else if (stallreq_if)                       stall = 6'b000011;
    end

    assign state_dbg = state;

`ifdef PIPE_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall[0] && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
            if (flush && !(&flush_count))     flush_count  <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (4-cycle and 1-cycle multi ops) driven by
// shared directed and random stimulus, checked against a behavioural model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_mem;
    logic        ex_multi_start, excp_valid;
    logic [31:0] excp_target;

    logic [5:0]  stall0, stall1;
    logic        flush0, flush1, busy0, busy1, done0, busy_unused, done1;
    logic [31:0] flush_pc0, flush_pc1;
    logic [1:0]  state_dbg0, state_dbg1;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cycles0, stall_cycles1;
    logic [15:0] flush_count0, flush_count1;
`endif

    int tests = 0;
    int fails = 0;

    // Model state: per-instance op tracking; flush timing is shared because it
    // depends only on excp_valid/rst history.
    bit          m_busy [2];
    int          m_left [2];
    bit          m_fl;
    logic [31:0] exp_q[$];
`ifdef PIPE_STALL_CNT_EN
    longint      m_stall_cyc [2];
    longint      m_flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_ctrl #(.MULTI_CYCLES(4), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
        .ex_multi_start(ex_multi_start), .excp_valid(excp_valid), .excp_target(excp_target),
        .stall(stall0), .flush(flush0), .flush_pc(flush_pc0),
        .multi_busy(busy0), .multi_done(done0), .state_dbg(state_dbg0)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cycles(stall_cycles0), .flush_count(flush_count0)
`endif
    );

    pipe_ctrl #(.MULTI_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
        .ex_multi_start(ex_multi_start), .excp_valid(excp_valid), .excp_target(excp_target),
        .stall(stall1), .flush(flush1), .flush_pc(flush_pc1),
        .multi_busy(busy1), .multi_done(done1), .state_dbg(state_dbg1)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cycles(stall_cycles1), .flush_count(flush_count1)
`endif
    );

    assign busy_unused = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int op_len(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic check_dut(input int k, input logic [5:0] st, input logic fl,
                             input logic [31:0] fpc, input logic busy, input logic done);
        logic       e_done;
        logic [5:0] e_stall;
        e_done = m_busy[k] && (m_left[k] == 0) && !stallreq_mem && !excp_valid;
        if (m_fl)                          e_stall = 6'b000000;
        else if (stallreq_mem)             e_stall = 6'b011111;
        else if (m_busy[k] && !e_done)     e_stall = 6'b001111;
        else if (stallreq_id)              e_stall = 6'b000111;
        else if (stallreq_if)              e_stall = 6'b000011;
        else                               e_stall = 6'b000000;
        check($sformatf("d%0d.stall", k), 32'(st), 32'(e_stall));
        check($sformatf("d%0d.flush", k), 32'(fl), 32'(m_fl));
        check($sformatf("d%0d.multi_busy", k), 32'(busy), 32'(m_busy[k]));
        check($sformatf("d%0d.multi_done", k), 32'(done), 32'(e_done));
        if (m_fl && exp_q.size() > 0)
            check($sformatf("d%0d.flush_pc", k), fpc, exp_q[0]);
`ifdef PIPE_STALL_CNT_EN
        if (!rst && e_stall[0] && m_stall_cyc[k] < 64'hFFFF_FFFF) m_stall_cyc[k]++;
`endif
    endtask

    task automatic model_update();
        if (rst) begin
            m_busy = '{0, 0};
            m_left = '{0, 0};
            m_fl   = 1'b0;
            exp_q.delete();
`ifdef PIPE_STALL_CNT_EN
            m_stall_cyc = '{0, 0};
            m_flush_cnt = 0;
`endif
        end else if (m_fl) begin
            m_fl = 1'b0;
            void'(exp_q.pop_front());
`ifdef PIPE_STALL_CNT_EN
            if (m_flush_cnt < 64'hFFFF) m_flush_cnt++;
`endif
        end else if (excp_valid) begin
            m_fl = 1'b1;
            exp_q.push_back(excp_target);
            m_busy = '{0, 0};
            m_left = '{0, 0};
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_busy[k]) begin
                    if (m_left[k] > 0)     m_left[k]--;
                    else if (!stallreq_mem) m_busy[k] = 1'b0;
                end else if (ex_multi_start) begin
                    m_busy[k] = 1'b1;
                    m_left[k] = op_len(k) - 1;
                end
            end
        end
    endtask

    // One clock: drive at the falling edge, check mid-cycle, then advance the model.
    task automatic cycle(input logic r, input logic rif, input logic rid, input logic rmem,
                         input logic st, input logic ex, input logic [31:0] tgt);
        @(negedge clk);
        rst = r; stallreq_if = rif; stallreq_id = rid; stallreq_mem = rmem;
        ex_multi_start = st; excp_valid = ex; excp_target = tgt;
        #1;
        check_dut(0, stall0, flush0, flush_pc0, busy0, done0);
        check_dut(1, stall1, flush1, flush_pc1, busy1, done1);
`ifdef PIPE_STALL_CNT_EN
        check("d0.stall_cycles", stall_cycles0, 32'(m_stall_cyc[0]));
        check("d0.flush_count", 32'(flush_count0), 32'(m_flush_cnt));
        check("d1.flush_count", 32'(flush_count1), 32'(m_flush_cnt));
`endif
        model_update();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; stallreq_if = 0; stallreq_id = 0; stallreq_mem = 0;
        ex_multi_start = 0; excp_valid = 0; excp_target = '0;
        m_busy = '{0, 0}; m_left = '{0, 0}; m_fl = 1'b0;
`ifdef PIPE_STALL_CNT_EN
        m_stall_cyc = '{0, 0}; m_flush_cnt = 0;
`endif
        repeat (2) @(posedge clk);
        cycle(1, 0, 0, 0, 0, 0, 32'h0);
        idle(5);
        // ID hazard over IF miss, then IF alone
        cycle(0, 1, 1, 0, 0, 0, 32'h0);
        cycle(0, 1, 1, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 0, 0, 32'h0);
        idle(2);
        // plain multi-cycle op
        cycle(0, 0, 0, 0, 1, 0, 32'h0);
        idle(6);
        // multi-cycle op with MEM stall T+3..T+6
        cycle(0, 0, 0, 0, 1, 0, 32'h0);
        idle(2);
        repeat (4) cycle(0, 0, 0, 1, 0, 0, 32'h0);
        idle(3);
        // exception aborts multi-cycle op at T+2
        cycle(0, 0, 0, 0, 1, 0, 32'h0);
        idle(1);
        cycle(0, 0, 0, 0, 0, 1, 32'hBFC0_0380);
        idle(3);
        // start and exception together
        cycle(0, 0, 0, 0, 1, 1, 32'h8000_0180);
        idle(3);
        // exception in the flush cycle is ignored
        cycle(0, 0, 0, 0, 0, 1, 32'h1234_5678);
        cycle(0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
        idle(2);
        // reset mid-op and during a pending flush
        cycle(0, 0, 0, 0, 1, 0, 32'h0);
        idle(1);
        cycle(1, 0, 0, 0, 0, 0, 32'h0);
        idle(2);
        cycle(0, 0, 0, 0, 0, 1, 32'hCAFE_0000);
        cycle(1, 0, 0, 0, 0, 0, 32'h0);
        idle(2);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 63) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core. Collects stall requests from IF, ID and MEM and sequences multi-cycle EX operations (divider). Handles exception/flush requests from MEM. Drives the per-stage stall vector consumed by pc_reg and every inter-stage register (if_id, id_ex, ex_mem, mem_wb), plus a one-cycle flush with redirect PC.

Parameters:
MULTI_CYCLES, 32, cycles an EX multi-cycle op occupies (legal range 1..255)
CNT_W, 8, width of the multi-cycle down-counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high (`RstEnable)
stallreq_if  in  1  IF waiting on instruction memory
stallreq_id  in  1  ID load-use hazard
stallreq_mem  in  1  MEM waiting on data bus
ex_multi_start  in  1  EX issues a multi-cycle op this cycle
excp_valid  in  1  MEM reports exception/eret; flush required
excp_target  in  32  redirect address (`InstAddrBus)
stall  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb
flush  out  1  one-cycle pulse; clears all inter-stage registers
flush_pc  out  32  PC to load when flush=1
multi_busy  out  1  multi-cycle op in progress
multi_done  out  1  one-cycle pulse; EX result valid this cycle

Behaviour:
- Reset: state=IDLE, counter=0, stall=6'b0, flush=0, flush_pc=`ZeroWord, multi_busy=0, multi_done=0.
- States: IDLE, MULTI, FLUSH.
- stall is combinational from the current state and requests. Priority, highest first:
  - state FLUSH -> 6'b000000
  - stallreq_mem -> 6'b011111
  - state MULTI and not done -> 6'b001111
  - stallreq_id -> 6'b000111
  - stallreq_if -> 6'b000011
  - otherwise -> 6'b000000
- A stalled stage whose successor is not stalled inserts a bubble (downstream register loads `ZeroWord`).
- IDLE:
  - excp_valid -> FLUSH; register flush_pc<=excp_target.
  - else if ex_multi_start -> MULTI; counter<=MULTI_CYCLES-1.
- MULTI:
  - multi_busy=1. Counter decrements each cycle while >0, regardless of other stalls.
  - When counter==0 and stallreq_mem==0: multi_done=1 for that cycle, stall[3] released, next state IDLE.
  - When counter==0 and stallreq_mem==1: hold at 0 in MULTI, multi_done=0, until stallreq_mem drops.
  - ex_multi_start is ignored.
- FLUSH: flush=1 and flush_pc valid for exactly one cycle, then IDLE. ex_multi_start and excp_valid are ignored in this cycle.
- excp_valid outranks everything in any state:
  - In MULTI: the op is aborted; counter<=0, multi_done never pulses, next state FLUSH.
  - Simultaneous excp_valid and ex_multi_start: flush wins; start is dropped.
- MULTI_CYCLES=1: multi_done asserts the cycle after the start cycle.
- Reset mid-operation returns to IDLE with all outputs at reset values on the next edge; no pending flush survives.

Optional Feature:
PIPE_STALL_CNT_EN
- Defined: adds outputs stall_cycles (32) and flush_count (16).
  - stall_cycles increments every cycle stall[0]==1.
  - flush_count increments on every flush pulse.
  - Both saturate at all-ones and clear on rst.
- Undefined: ports and logic absent; core behaviour unchanged.

Test Plan:
- Reset, then rst=0 with no requests -> stall=0, flush=0, multi_busy=0 for 5 cycles.
- stallreq_id=1 for 2 cycles, stallreq_if=1 throughout -> stall=6'b000111 twice, then 6'b000011.
- MULTI_CYCLES=4, ex_multi_start pulse at cycle T -> multi_busy T+1..T+4, stall=6'b001111 T+1..T+3, multi_done=1 and stall=0 at T+4.
- Same op with stallreq_mem=1 from T+3 to T+6 -> stall=6'b011111 T+3..T+6, multi_done delayed to T+7.
- excp_valid=1, excp_target=32'hBFC00380 during MULTI at T+2 -> flush=1, flush_pc=32'hBFC00380, stall=0 at T+3; no multi_done; state IDLE at T+4.
- ex_multi_start and excp_valid in the same cycle -> single flush pulse, multi_busy stays 0.
